// File: rtl/seg_display_ctrl_if.sv
// Bus bundle between the debug/peek data source and seg_display_ctrl.
// master drives load/data/control, slave (the controller) drives the display pins.
interface seg_display_ctrl_if #(
   parameter int DIGITS = 6
);
   logic                  load_i;
   logic [4*DIGITS-1:0]   data_i;
   logic                  freeze_i;
   logic                  blank_lz_i;
   logic [DIGITS-1:0]     blink_mask_i;
   logic [7*DIGITS-1:0]   seg_o;
   logic [6:0]            scan_seg_o;
   logic [DIGITS-1:0]     scan_en_o;
   logic                  updated_o;

   modport master (
      output load_i, data_i, freeze_i, blank_lz_i, blink_mask_i,
      input  seg_o, scan_seg_o, scan_en_o, updated_o
   );

   modport slave (
      input  load_i, data_i, freeze_i, blank_lz_i, blink_mask_i,
      output seg_o, scan_seg_o, scan_en_o, updated_o
   );
endinterface

// File: rtl/seg_display_ctrl.sv
// Hex 7-segment display controller: load/freeze capture, leading-zero blanking,
// per-digit blink and optional time-multiplexed scan output.
module seg_display_ctrl #(
   parameter int DIGITS     = 6,
   parameter int ACTIVE_LOW = 1,
   parameter int SCAN       = 0,
   parameter int SCAN_DIV   = 50000,
   parameter int BLINK_DIV  = 25000000
) (
   input  logic              clk,
   input  logic              rst_n,
   seg_display_ctrl_if.slave bus
);
   localparam int         BW      = $clog2(BLINK_DIV);
   localparam logic [6:0] SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic       EN_OFF  = (ACTIVE_LOW != 0);

   typedef enum logic {PH_VISIBLE, PH_HIDDEN} phase_t;

   logic [4*DIGITS-1:0] r_disp;
   logic                r_updated;
   logic [BW-1:0]       r_blink_cnt;
   phase_t              r_phase;
   logic [7*DIGITS-1:0] r_seg;
   logic                w_load;
   logic                w_lead;
   logic [DIGITS-1:0]   w_off;
   logic [7*DIGITS-1:0] w_seg_ah;
   logic [7*DIGITS-1:0] w_seg;

   function automatic logic [6:0] f_dec(input logic [3:0] d);
      case (d)
         4'h0: f_dec = 7'h3F;  4'h1: f_dec = 7'h06;
         4'h2: f_dec = 7'h5B;  4'h3: f_dec = 7'h4F;
         4'h4: f_dec = 7'h66;  4'h5: f_dec = 7'h6D;
         4'h6: f_dec = 7'h7D;  4'h7: f_dec = 7'h07;
         4'h8: f_dec = 7'h7F;  4'h9: f_dec = 7'h6F;
         4'hA: f_dec = 7'h77;  4'hB: f_dec = 7'h7C;
         4'hC: f_dec = 7'h39;  4'hD: f_dec = 7'h5E;
         4'hE: f_dec = 7'h79;  default: f_dec = 7'h71;
      endcase
   endfunction

   assign w_load = bus.load_i & ~bus.freeze_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_disp    <= '0;
         r_updated <= 1'b0;
      end else begin
         r_updated <= w_load;
         if (w_load)
            r_disp <= bus.data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_blink_cnt <= '0;
         r_phase     <= PH_VISIBLE;
      end else if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
         r_blink_cnt <= '0;
         r_phase     <= (r_phase == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
      end else begin
         r_blink_cnt <= r_blink_cnt + 1'b1;
      end
   end

   // Walk from the top digit down; w_lead stays set while every digit so far is zero.
   always_comb begin
      w_lead   = 1'b1;
      w_off    = '0;
      w_seg_ah = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         int unsigned k;
         k        = DIGITS - 1 - i;
         w_lead   = w_lead & (r_disp[4*k +: 4] == 4'h0);
         w_off[k] = (bus.blank_lz_i & w_lead & (k != 0))
                  | ((r_phase == PH_HIDDEN) & bus.blink_mask_i[k]);
         w_seg_ah[7*k +: 7] = w_off[k] ? 7'h00 : f_dec(r_disp[4*k +: 4]);
      end
   end

   assign w_seg = (ACTIVE_LOW != 0) ? ~w_seg_ah : w_seg_ah;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_seg <= {DIGITS{SEG_OFF}};
      else
         r_seg <= w_seg;
   end

   assign bus.seg_o     = r_seg;
   assign bus.updated_o = r_updated;

   if (SCAN != 0) begin : g_scan
      localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
      localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

      logic [SW-1:0]     r_scan_cnt;
      logic [IW-1:0]     r_idx;
      logic [6:0]        r_scan_seg;
      logic [DIGITS-1:0] r_scan_en;
      logic [DIGITS-1:0] w_onehot;

      assign w_onehot = DIGITS'(1) << r_idx;

      // Enable and segments are both captured from the same index, keeping them aligned.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
            r_scan_seg <= SEG_OFF;
            r_scan_en  <= {DIGITS{EN_OFF}};
         end else begin
            r_scan_seg <= w_seg[7*r_idx +: 7];
            r_scan_en  <= (ACTIVE_LOW != 0) ? ~w_onehot : w_onehot;
            if (r_scan_cnt == SW'(SCAN_DIV - 1)) begin
               r_scan_cnt <= '0;
               r_idx      <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
            end else begin
               r_scan_cnt <= r_scan_cnt + 1'b1;
            end
         end
      end

      assign bus.scan_seg_o = r_scan_seg;
      assign bus.scan_en_o  = r_scan_en;
   end else begin : g_static
      assign bus.scan_seg_o = SEG_OFF;
      assign bus.scan_en_o  = {DIGITS{EN_OFF}};
   end
endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl: a 6-digit static instance and a
// 4-digit scanning instance, with a queue of expected display values.
module tb_seg_display_ctrl;
   logic clk;
   logic rst_n;

   seg_display_ctrl_if #(.DIGITS(6)) if6 ();
   seg_display_ctrl_if #(.DIGITS(4)) if4 ();

   seg_display_ctrl #(
      .DIGITS(6), .ACTIVE_LOW(1), .SCAN(0), .SCAN_DIV(2), .BLINK_DIV(4)
   ) u_dut6 (
      .clk(clk), .rst_n(rst_n), .bus(if6)
   );

   seg_display_ctrl #(
      .DIGITS(4), .ACTIVE_LOW(1), .SCAN(1), .SCAN_DIV(2), .BLINK_DIV(4)
   ) u_dut4 (
      .clk(clk), .rst_n(rst_n), .bus(if4)
   );

   typedef struct {
      string       tag;
      logic [63:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_total);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic sb_push(input string tag, input logic [63:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic sb_check(input logic [63:0] obs);
      exp_t e;
      if (sb.size() == 0) begin
         chk("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
         e = sb.pop_front();
         chk(e.tag, obs, e.val);
      end
   endtask

   // Load through the 6-digit instance; the display value is expected two edges later.
   task automatic do_load(input string tag, input logic [23:0] data, input logic frz,
                          input logic [41:0] exp_seg, input logic exp_upd);
      if6.data_i   = data;
      if6.load_i   = 1'b1;
      if6.freeze_i = frz;
      sb_push(tag, 64'(exp_seg));
      tick();
      if6.load_i = 1'b0;
      chk({tag, "_upd"}, 64'(if6.updated_o), 64'(exp_upd));
      tick();
      chk({tag, "_upd_end"}, 64'(if6.updated_o), 64'd0);
      sb_check(64'(if6.seg_o));
      if6.freeze_i = 1'b0;
   endtask

   initial begin
      logic [6:0]  s[24];
      logic [6:0]  v;
      logic        found;
      logic        hid_t;
      logic        hid;
      int          t;
      logic [3:0]  prev_en;
      logic [3:0]  en_tab[4];
      logic [6:0]  seg_tab[4];

      en_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      seg_tab = '{7'h19, 7'h30, 7'h24, 7'h79};

      rst_n = 1'b0;
      if6.load_i = 1'b0; if6.data_i = '0; if6.freeze_i = 1'b0;
      if6.blank_lz_i = 1'b0; if6.blink_mask_i = '0;
      if4.load_i = 1'b0; if4.data_i = '0; if4.freeze_i = 1'b0;
      if4.blank_lz_i = 1'b0; if4.blink_mask_i = '0;

      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      tick();
      chk("release_zero", 64'(if6.seg_o), 64'({6{7'h40}}));
      chk("noscan_static", {51'd0, if6.scan_en_o, if6.scan_seg_o}, {51'd0, 6'h3F, 7'h7F});

      // Reset asserted mid-run while updated_o is high
      if6.data_i = 24'h123456;
      if6.load_i = 1'b1;
      tick();
      if6.load_i = 1'b0;
      chk("pre_reset_upd", 64'(if6.updated_o), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("reset_seg", 64'(if6.seg_o), 64'({6{7'h7F}}));
      chk("reset_upd", 64'(if6.updated_o), 64'd0);
      chk("reset_scan", {53'd0, if4.scan_en_o, if4.scan_seg_o}, {53'd0, 4'hF, 7'h7F});
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      chk("release_zero2", 64'(if6.seg_o), 64'({6{7'h40}}));

      if4.data_i = 16'h1234;
      if4.load_i = 1'b1;
      tick();
      if4.load_i = 1'b0;

      if6.blank_lz_i = 1'b1;
      do_load("lz_0A1234", 24'h0A1234, 1'b0,
              {7'h7F, 7'h08, 7'h79, 7'h24, 7'h30, 7'h19}, 1'b1);
      do_load("lz_zero", 24'h000000, 1'b0,
              {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b1);
      do_load("freeze_load", 24'hFFFFFF, 1'b1,
              {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b0);
      do_load("unfrozen_load", 24'hFFFFFF, 1'b0, {6{7'h0E}}, 1'b1);
      do_load("lz_inner_zero", 24'h100200, 1'b0,
              {7'h79, 7'h40, 7'h40, 7'h24, 7'h40, 7'h40}, 1'b1);
      if6.blank_lz_i = 1'b0;
      do_load("nolz_000300", 24'h000300, 1'b0,
              {7'h40, 7'h40, 7'h40, 7'h30, 7'h40, 7'h40}, 1'b1);
      if6.blank_lz_i = 1'b1;
      tick();
      chk("lz_toggle", 64'(if6.seg_o),
          64'({7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h40, 7'h40}));

      // Blink on digit 0; phase is found from the samples, then checked including a mid-blink load
      if6.blank_lz_i   = 1'b0;
      if6.blink_mask_i = 6'b000001;
      if6.data_i       = 24'h000005;
      if6.load_i       = 1'b1;
      tick();
      if6.load_i = 1'b0;
      tick();
      for (int i = 0; i < 24; i++) begin
         tick();
         s[i] = if6.seg_o[6:0];
         chk("blink_others", 64'(if6.seg_o[41:7]), 64'({5{7'h40}}));
         if (i == 9) begin
            if6.data_i = 24'h000007;
            if6.load_i = 1'b1;
         end
         if (i == 10)
            if6.load_i = 1'b0;
      end
      found = 1'b0;
      t     = 0;
      for (int i = 1; i <= 4; i++) begin
         if (!found && s[i] !== s[i-1]) begin
            found = 1'b1;
            t     = i;
         end
      end
      chk("blink_edge_found", 64'(found), 64'd1);
      if (found) begin
         hid_t = (s[t] == 7'h7F);
         for (int i = t; i < 24; i++) begin
            v   = (i >= 11) ? 7'h78 : 7'h12;
            hid = ((((i - t) / 4) % 2) == 0) ? hid_t : !hid_t;
            chk("blink_digit0", 64'(s[i]), 64'(hid ? 7'h7F : v));
         end
      end
      if6.blink_mask_i = '0;

      // Scan: align on the slot boundary where digit 0 becomes active
      found   = 1'b0;
      prev_en = if4.scan_en_o;
      for (int i = 0; i < 20; i++) begin
         if (!found) begin
            tick();
            if (if4.scan_en_o == 4'b1110 && prev_en != 4'b1110)
               found = 1'b1;
            prev_en = if4.scan_en_o;
         end
      end
      chk("scan_sync_found", 64'(found), 64'd1);
      if (found) begin
         for (int j = 0; j < 12; j++)
            sb_push("scan_slot", {53'd0, en_tab[(j/2)%4], seg_tab[(j/2)%4]});
         for (int j = 0; j < 12; j++) begin
            if (j != 0)
               tick();
            sb_check({53'd0, if4.scan_en_o, if4.scan_seg_o});
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
